// File: rtl/regfile_pkg.sv
// Shared types for the register-file writeback path.
package regfile_pkg;

  localparam int unsigned REG_AW    = 5;
  localparam int unsigned WB_DATA_W = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t              addr;
    logic [WB_DATA_W-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index, rotating priority pointer.
module rr_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   gidx,
  output logic            gvalid
);

  logic [IW-1:0] ptr;
  logic [IW:0]   cand;

  // Search upward from the pointer, wrapping at NREQ-1; first requester wins.
  always_comb begin
    grant  = '0;
    gidx   = '0;
    gvalid = 1'b0;
    cand   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (IW+1)'(ptr) + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (!gvalid && req[cand[IW-1:0]]) begin
        gvalid                = 1'b1;
        grant[cand[IW-1:0]]   = 1'b1;
        gidx                  = cand[IW-1:0];
      end
    end
  end

  // Pointer moves to the slot after the accepted requester.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gidx == IW'(NREQ-1)) ? '0 : gidx + IW'(1);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port among NREQ writeback sources and tracks pending writes.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned N    = 32,
  parameter int unsigned L    = 32,
  parameter int unsigned NREQ = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ-1:0][REG_AW-1:0]  req_addr,
  input  logic [NREQ-1:0][N-1:0]       req_data,
  output logic [NREQ-1:0]              req_ready,
  input  logic                         rsv_valid,
  input  logic [REG_AW-1:0]            rsv_addr,
  input  logic [REG_AW-1:0]            ra1,
  input  logic [REG_AW-1:0]            ra2,
  output logic                         hz1,
  output logic                         hz2,
  output logic                         we3,
  output logic [REG_AW-1:0]            wa3,
  output logic [N-1:0]                 wd3,
  output logic [L-1:0]                 pending,
  output logic                         idle
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [NREQ-1:0] grant;
  logic [IW-1:0]   gidx;
  logic            gvalid;
  logic            accept;
  reg_addr_t       sel_addr;
  logic [N-1:0]    sel_data;
  logic [L-1:0]    pending_n;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .advance(accept),
    .grant  (grant),
    .gidx   (gidx),
    .gvalid (gvalid)
  );

  // Grant is suppressed while reset is held so nothing is consumed then.
  always_comb begin
    accept    = gvalid & ~reset;
    req_ready = reset ? '0 : grant;
    sel_addr  = req_addr[gidx];
    sel_data  = req_data[gidx];
  end

  // Write-port register; an accepted write to r0 is consumed without enabling we3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else if (accept) begin
      we3 <= (sel_addr != '0);
      wa3 <= sel_addr;
      wd3 <= sel_data;
    end else begin
      we3 <= 1'b0;
    end
  end

  // Scoreboard next state: clear on accept, then set on reservation so a new reservation wins.
  always_comb begin
    pending_n = pending;
    for (int unsigned r = 1; r < L; r++) begin
      if (accept && sel_addr == REG_AW'(r)) begin
        pending_n[r] = 1'b0;
      end
      if (rsv_valid && rsv_addr == REG_AW'(r)) begin
        pending_n[r] = 1'b1;
      end
    end
    pending_n[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_n;
    end
  end

  // Read hazards against the scoreboard; r0 never stalls.
  always_comb begin
    hz1 = 1'b0;
    hz2 = 1'b0;
    for (int unsigned r = 1; r < L; r++) begin
      if (ra1 == REG_AW'(r)) hz1 = pending[r];
      if (ra2 == REG_AW'(r)) hz2 = pending[r];
    end
    idle = ~|pending & ~|req_valid & ~we3;
  end

endmodule
